button_conditioner: RTL and testbench



---
 rtl/button_conditioner.sv | 150 +++++++++++++++
 tb/tb_button_conditioner.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Per-channel 2-flop synchronizer, stability-count debounce and press-edge pulse generator.
// Define BUTTON_CONDITIONER_AUTOREPEAT_EN to add hold-to-repeat press pulses.
module button_conditioner #(
   parameter int N_CH            = 7,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REPEAT_DELAY    = 50000000,
   parameter int REPEAT_PERIOD   = 20000000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N_CH-1:0] raw_in,
   output logic [N_CH-1:0] level_out,
   output logic [N_CH-1:0] press_pulse,
   output logic            any_press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [N_CH-1:0] sync1;
   logic [N_CH-1:0] sync2;
   logic [N_CH-1:0] stab;
   logic [N_CH-1:0] rise;
   logic [N_CH-1:0] rep_pulse;
   logic [N_CH-1:0] pulse_next;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= raw_in;
         sync2 <= sync1;
      end
   end

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
   typedef enum logic [1:0] {IDLE, HOLD_WAIT, REPEAT} rep_state_t;

   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW = $clog2(RMAX + 1);
   localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
`endif

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      logic [CW-1:0] cnt;
      logic          stab_q;
      logic          accept;

      // A level change is accepted once the synced input has disagreed with
      // the stable value for DEBOUNCE_CYCLES consecutive edges.
      assign accept = (sync2[g] != stab_q) && (cnt == CNT_LAST);

      always_ff @(posedge clk) begin
         if (reset) begin
            cnt    <= '0;
            stab_q <= 1'b0;
         end else if (sync2[g] == stab_q) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            stab_q <= ~stab_q;
            cnt    <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end

      assign stab[g] = stab_q;
      assign rise[g] = accept && !stab_q;

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
      logic          fall;
      rep_state_t    state;
      rep_state_t    state_next;
      logic [RW-1:0] rcnt;
      logic [RW-1:0] rcnt_next;
      logic          rep;

      assign fall = accept && stab_q;

      always_ff @(posedge clk) begin
         if (reset) begin
            state <= IDLE;
            rcnt  <= '0;
         end else begin
            state <= state_next;
            rcnt  <= rcnt_next;
         end
      end

      // Release wins over everything so no repeat pulse can follow it.
      always_comb begin
         state_next = state;
         rcnt_next  = rcnt;
         rep        = 1'b0;
         if (fall) begin
            state_next = IDLE;
            rcnt_next  = '0;
         end else if (rise[g]) begin
            state_next = HOLD_WAIT;
            rcnt_next  = '0;
         end else begin
            case (state)
               HOLD_WAIT: begin
                  if (rcnt == DELAY_LAST) begin
                     rep        = 1'b1;
                     state_next = REPEAT;
                     rcnt_next  = '0;
                  end else begin
                     rcnt_next = rcnt + RW'(1);
                  end
               end
               REPEAT: begin
                  if (rcnt == PERIOD_LAST) begin
                     rep       = 1'b1;
                     rcnt_next = '0;
                  end else begin
                     rcnt_next = rcnt + RW'(1);
                  end
               end
               default: begin
                  state_next = IDLE;
                  rcnt_next  = '0;
               end
            endcase
         end
      end

      assign rep_pulse[g] = rep;
`else
      assign rep_pulse[g] = 1'b0;
`endif
   end

   assign pulse_next = rise | rep_pulse;
   assign level_out  = stab;

   // Pulses are registered so they line up with the edge where stab changes.
   always_ff @(posedge clk) begin
      if (reset) begin
         press_pulse <= '0;
         any_press   <= 1'b0;
      end else begin
         press_pulse <= pulse_next;
         any_press   <= |pulse_next;
      end
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: a history-based reference model compared every
// cycle, plus directed literal expectations for latency, bounce, glitch, reset and repeat.
module tb_button_conditioner;

   localparam int N_CH = 7;
   localparam int DEB  = 4;
   localparam int RDEL = 10;
   localparam int RPER = 3;

   logic            clk = 1'b0;
   logic            reset;
   logic [N_CH-1:0] raw_in;
   logic [N_CH-1:0] level_out;
   logic [N_CH-1:0] press_pulse;
   logic            any_press;

   int errorCount = 0;
   int checkCount = 0;
   bit compareEn  = 1'b0;

   always #5 clk = ~clk;

   button_conditioner #(
      .N_CH           (N_CH),
      .DEBOUNCE_CYCLES(DEB),
      .REPEAT_DELAY   (RDEL),
      .REPEAT_PERIOD  (RPER)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .raw_in     (raw_in),
      .level_out  (level_out),
      .press_pulse(press_pulse),
      .any_press  (any_press)
   );

   task automatic checkOutput(input string name, input logic [N_CH-1:0] actual,
                              input logic [N_CH-1:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: actual=%b required=%b at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic [N_CH-1:0] value, input int cycles);
      raw_in = value;
      repeat (cycles) @(negedge clk);
   endtask

   // Reference model: hist holds what raw_in looked like at each past edge
   // (bit 0 = previous edge). A level is accepted once the two-edge-delayed
   // input has disagreed with the accepted level for DEB edges in a row.
   logic [15:0]     hist [N_CH];
   logic [N_CH-1:0] modelLevel;
   logic [N_CH-1:0] modelPulse;
   bit              allDiff;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
   int              age [N_CH];
`endif

   always @(posedge clk) begin
      for (int i = 0; i < N_CH; i++) begin
         if (reset) begin
            hist[i]       = '0;
            modelLevel[i] = 1'b0;
            modelPulse[i] = 1'b0;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
            age[i] = 0;
`endif
         end else begin
            allDiff = 1'b1;
            for (int j = 1; j <= DEB; j++)
               if (hist[i][j] == modelLevel[i]) allDiff = 1'b0;
            modelPulse[i] = 1'b0;
            if (allDiff) begin
               modelLevel[i] = ~modelLevel[i];
               if (modelLevel[i]) begin
                  modelPulse[i] = 1'b1;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
                  age[i] = 0;
`endif
               end
            end
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
            else if (modelLevel[i]) begin
               age[i]++;
               if (age[i] == RDEL || (age[i] > RDEL && (age[i] - RDEL) % RPER == 0))
                  modelPulse[i] = 1'b1;
            end
`endif
            hist[i] = {hist[i][14:0], raw_in[i]};
         end
      end
   end

   always @(negedge clk) begin
      if (compareEn) begin
         checkOutput("model_level", level_out, modelLevel);
         checkOutput("model_pulse", press_pulse, modelPulse);
         checkOutput("model_any", {6'b0, any_press}, {6'b0, |modelPulse});
      end
   end

   initial begin
      int   pulses;
      bit   sawHigh;
      logic [0:9] bounce;

      reset  = 1'b1;
      raw_in = '0;
      repeat (3) @(negedge clk);
      checkOutput("reset_level", level_out, '0);
      checkOutput("reset_pulse", press_pulse, '0);
      checkOutput("reset_any", {6'b0, any_press}, '0);
      reset     = 1'b0;
      compareEn = 1'b1;
      applyStimulus('0, 3);

      $display("[TB] clean press on ch0");
      raw_in = 7'b0000001;
      for (int j = 1; j <= 20; j++) begin
         @(negedge clk);
         if (j <= 7) checkOutput("t1_pulse", press_pulse, (j == 6) ? 7'b0000001 : 7'b0);
         if (j == 5) checkOutput("t1_level_before", level_out, 7'b0);
         if (j == 6) checkOutput("t1_any", {6'b0, any_press}, 7'b1);
      end
      raw_in = '0;
      for (int j = 1; j <= 10; j++) begin
         @(negedge clk);
         if (j == 5) checkOutput("t1_release_hold", level_out, 7'b0000001);
         if (j == 6) checkOutput("t1_release_fall", level_out, 7'b0);
      end

      $display("[TB] bounce on ch2");
      bounce = 10'b1011011111;
      pulses = 0;
      for (int j = 0; j < 16; j++) begin
         raw_in[2] = (j < 10) ? bounce[j] : 1'b1;
         @(negedge clk);
         if (press_pulse[2]) pulses++;
         if (j == 9) checkOutput("t2_level_early", level_out, 7'b0);
      end
      checkOutput("t2_pulse_count", 7'(pulses), 7'd1);
      checkOutput("t2_level", level_out, 7'b0000100);
      applyStimulus('0, 10);

      $display("[TB] glitch on ch3");
      pulses  = 0;
      sawHigh = 1'b0;
      for (int j = 0; j < 13; j++) begin
         raw_in[3] = (j < 3);
         @(negedge clk);
         if (press_pulse[3]) pulses++;
         if (level_out[3]) sawHigh = 1'b1;
      end
      checkOutput("t3_pulse_count", 7'(pulses), 7'd0);
      checkOutput("t3_level_seen", {6'b0, sawHigh}, 7'b0);

      $display("[TB] simultaneous ch1 and ch5");
      raw_in = 7'b0100010;
      for (int j = 1; j <= 8; j++) begin
         @(negedge clk);
         checkOutput("t4_pulse", press_pulse, (j == 6) ? 7'b0100010 : 7'b0);
         if (j == 6) checkOutput("t4_any", {6'b0, any_press}, 7'b1);
      end
      applyStimulus('0, 10);

      $display("[TB] reset mid-count on ch4");
      applyStimulus(7'b0010000, 4);
      reset = 1'b1;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         checkOutput("t5_reset_level", level_out, 7'b0);
         checkOutput("t5_reset_pulse", press_pulse, 7'b0);
      end
      reset = 1'b0;
      for (int j = 1; j <= 8; j++) begin
         @(negedge clk);
         checkOutput("t5_pulse", press_pulse, (j == 6) ? 7'b0010000 : 7'b0);
      end
      applyStimulus('0, 10);

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
      $display("[TB] auto-repeat on ch0");
      raw_in = 7'b0000001;
      for (int j = 1; j <= 50; j++) begin
         @(negedge clk);
         checkOutput("t6_pulse", press_pulse,
                     (j inside {6, 16, 19, 22, 25, 28, 31, 34, 37, 40}) ? 7'b0000001 : 7'b0);
         if (j == 36) raw_in = '0;
      end
`endif

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
